// File: rtl/transmissor_ascii_uc.sv
// Control unit of the ASCII message transmitter: walks the character index
// through the 7O1 serial transmitter, one start pulse per character, with an idle gap.
module transmissor_ascii_uc #(
    parameter int N_CHARS    = 8,
    parameter int SEL_W      = 3,
    parameter int GAP_CYCLES = 4,
    parameter int GAP_W      = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,      // asynchronous, active-low
    input  logic             iniciar_i,
    input  logic             parar_i,
    input  logic [SEL_W:0]   tamanho_i,
    input  logic             tx_pronto_i,
    output logic             tx_partida_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             ocupado_o,
    output logic             fim_o,
    output logic             abortado_o,
    output logic [3:0]       db_estado_o
);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        TRANSMITE = 4'd2,
        ESPERA    = 4'd3,
        INTERVALO = 4'd4,
        PROXIMO   = 4'd5,
        FINAL     = 4'd6,
        ABORTA    = 4'd7
    } estado_t;

    localparam logic [SEL_W:0]   MAX_LEN  = (SEL_W + 1)'(N_CHARS);
    localparam logic [SEL_W:0]   LEN_ONE  = (SEL_W + 1)'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    estado_t          state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W:0]   len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ultimo;

    assign ultimo = ({1'b0, sel_q} == (len_q - LEN_ONE));

    // NOTE: sequential state uses non-blocking assignments only, and every
    // register sits in the async reset branch so outputs drop without a clock.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= INICIAL;
            sel_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no path leaves a
    // latch behind.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        gap_d   = gap_q;
        case (state_q)
            INICIAL: if (iniciar_i && !parar_i) state_d = PREPARA;
            PREPARA: begin
                sel_d   = '0;
                len_d   = (tamanho_i > MAX_LEN) ? MAX_LEN : tamanho_i;
                state_d = (len_d == '0) ? FINAL : TRANSMITE;
            end
            TRANSMITE: state_d = ESPERA;
            ESPERA: begin
                if (tx_pronto_i) begin
                    if (ultimo) begin
                        state_d = FINAL;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = PROXIMO;
                    end else begin
                        state_d = INTERVALO;
                        gap_d   = '0;
                    end
                end
            end
            INTERVALO: begin
                gap_d = gap_q + GAP_ONE;
                if (gap_q == GAP_LAST) state_d = PROXIMO;
            end
            PROXIMO: begin
                sel_d   = sel_q + 1'b1;
                state_d = TRANSMITE;
            end
            FINAL:   state_d = INICIAL;
            ABORTA:  state_d = INICIAL;
            default: state_d = INICIAL;
        endcase

        // Abort wins over every other transition while a message is in flight.
        if (parar_i && (state_q inside {PREPARA, TRANSMITE, ESPERA, INTERVALO, PROXIMO}))
            state_d = ABORTA;
    end

    assign tx_partida_o = (state_q == TRANSMITE);
    assign ocupado_o    = (state_q != INICIAL);
    assign fim_o        = (state_q == FINAL);
    assign abortado_o   = (state_q == ABORTA);
    assign sel_o        = sel_q;
    assign db_estado_o  = state_q;

endmodule
